sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Single-clock FIFO, parametrised in width and depth. Successor to the fixed 8-bit FIFO.
//  Adds fill count, programmable almost-full/almost-empty, sticky overflow/underflow,
//  synchronous flush and an optional first-word-fall-through (FWFT) read mode.
//  Sits between any single-clock producer/consumer pair in the datapath.
// PARAMETERS
//  DATA_WIDTH  8   width of data_in/data_out
//  DEPTH       16  number of entries; power of two, >= 2
//  AF_THRESH   14  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   2   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  FWFT        0   0 = standard registered read; 1 = first-word-fall-through
// PORTS
//  clk           in   1               rising-edge clock
//  rst_n         in   1               reset, asynchronous, active-low
//  write_en      in   1               push data_in this cycle
//  read_en       in   1               pop head entry this cycle
//  flush         in   1               synchronous clear of contents and error flags
//  data_in       in   DATA_WIDTH      write data
//  data_out      out  DATA_WIDTH      read data
//  full          out  1               count == DEPTH
//  empty         out  1               count == 0
//  almost_full   out  1               count >= AF_THRESH
//  almost_empty  out  1               count <= AE_THRESH
//  count         out  $clog2(DEPTH)+1 current number of stored entries
//  overflow      out  1               sticky: a write was dropped
//  underflow     out  1               sticky: a read was ignored
// BEHAVIOUR
//  - Reset (rst_n=0, async): pointers=0, count=0, data_out=0, empty=1, almost_empty=1,
//    full=0, almost_full=0, overflow=0, underflow=0. Memory contents not reset.
//  - Pointers are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); natural wrap, extra MSB separates
//    full from empty. count is a register updated with the pointers; never exceeds DEPTH.
//  - All flags are decoded from registered state only: no input-to-output combinational path.
//  - Write accepted iff write_en && !full, with full sampled at the start of the cycle.
//    write_en && full -> data dropped, overflow set on next edge, even if read_en is also 1.
//  - Read accepted iff read_en && !empty, with empty sampled at the start of the cycle.
//    read_en && empty -> no pop, underflow set, even if write_en is also 1. The write is still taken.
//  - Simultaneous accepted write and read: both pointers advance, count unchanged.
//  - FWFT=0: on an accepted read, data_out <= head entry; valid the cycle after read_en
//    (1-cycle latency). data_out holds its value at all other times.
//  - FWFT=1: data_out = mem[rd_ptr] whenever !empty; read_en acknowledges/pops it.
//    The first write into an empty FIFO appears on data_out the cycle after the write edge.
//    When empty, data_out holds the last value popped (0 after reset).
//  - flush=1: next edge sets pointers=0 and count=0, clears overflow/underflow, and drops
//    any write/read in that cycle. Flush has priority over write/read. data_out unchanged.
//  - Async reset mid-operation discards all contents immediately; operation resumes on the
//    first edge after deassertion.
// STRUCTURE
//  - fifo_pkg.vh (shared include): clog2 helper function and the pointer-width localparam
//    formula; reused by every FIFO variant.
//  - Sub-module fifo_ram: simple dual-port array, 1 write port / 1 read port, no reset.
//    FWFT=1 uses its asynchronous read address; FWFT=0 uses a registered output.
//  - Top level holds pointers, count, flag decode, error stickies and flush logic.
// TESTING  (DATA_WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1, unless stated)
//  1 Reset, then write 5,10,15,20,25,30,35 on consecutive cycles -> count=7, almost_full=1,
//    full=0. Read 7 -> 5..35 in order, one cycle after each read_en; then empty=1, count=0.
//  2 Write 8 entries, then a 9th (0xAA) -> full=1, overflow=1, 0xAA never read out.
//    Read all 8 -> order intact.
//  3 Empty FIFO, read_en+write_en(0x11) same cycle -> underflow=1, count=1, next read returns 0x11.
//  4 Full FIFO, write+read same cycle -> overflow=1, count=7. Steady-state write+read with
//    count=4 for 20 cycles -> count stays 4, pointers wrap, data ordered.
//  5 count=5, flush=1 with write_en=1 -> count=0, empty=1, overflow/underflow=0.
//    Assert rst_n low mid-burst -> all outputs return to reset values with no clock edge.
//  6 FWFT=1: write 0x42 into empty -> data_out=0x42 next cycle with no read_en.
//    read_en -> next entry appears the following cycle.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised single-clock FIFO family.
// Holds the width helpers used to size pointers and the fill counter,
// plus the per-cycle operation encoding used by the count update.
package sync_fifo_param_pkg;

    // Ceiling log2, usable in constant expressions for localparams.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Pointer width: one address bit per entry index plus an extra MSB
    // that toggles on every wrap so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // What the FIFO actually does on a given edge once full/empty gating
    // and flush have been applied.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Storage array for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_param_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int ENTRIES = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    // Write port: store the incoming word at the write address on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow,
// synchronous flush and optional first-word-fall-through read mode.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  wr_ok;
    logic                  rd_ok;
    fifo_op_e              op;

    // Status flags come only from registered pointers and count, so no
    // input ever reaches an output combinationally.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                          (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    // A push or pop only happens when the FIFO state at the start of the
    // cycle allows it and no flush is pending.
    assign wr_ok = write_en && !full  && !flush;
    assign rd_ok = read_en  && !empty && !flush;

    // Classify the edge so the counter update reads as a single case.
    always_comb begin
        op = OP_IDLE;
        if (wr_ok && rd_ok) begin
            op = OP_BOTH;
        end else if (wr_ok) begin
            op = OP_WRITE;
        end else if (rd_ok) begin
            op = OP_READ;
        end
    end

    sync_fifo_param_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // Pointers, fill count and sticky error flags; flush wins over any
    // push or pop in the same cycle and also clears the error history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case (op)
                OP_WRITE: count <= count + CNT_W'(1);
                OP_READ:  count <= count - CNT_W'(1);
                default:  count <= count;
            endcase
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Output register: captures the head word on every accepted pop. In the
    // standard mode this is the read data; in fall-through mode it keeps the
    // last popped word visible once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (rd_ok) begin
            data_q <= ram_rd_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? data_q : ram_rd_data;
        end else begin : g_std
            assign data_out = data_q;
        end
    endgenerate

endmodule
